// File: rtl/nios2_debug_jtag_pkg.sv
// ---------------------------------------------------------------------------
// nios2_debug_jtag_pkg
// Shared types and constants for the Nios II virtual-JTAG debug host:
//   jtag_state_e      - host sequencer states
//   OCIMEM..TRACECTRL - IR codes understood by the CPU debug slave
//   DEFAULT_DR_WIDTH  - length of the debug-slave data register
// ---------------------------------------------------------------------------
package nios2_debug_jtag_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        DONE = 3'd6
    } jtag_state_e;

    localparam logic [1:0] OCIMEM    = 2'd0;
    localparam logic [1:0] TRACEMEM  = 2'd1;
    localparam logic [1:0] BREAK     = 2'd2;
    localparam logic [1:0] TRACECTRL = 2'd3;

    localparam int DEFAULT_DR_WIDTH = 38;

endpackage

// File: rtl/nios2_debug_jtag_host_if.sv
// ---------------------------------------------------------------------------
// nios2_debug_jtag_host_if
// Command / response handshake between a debug initiator and the JTAG host.
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr          - one debug command
//   rsp_valid/rsp_ready/rsp_dr/rsp_ir_out      - captured result
// modport master : the command issuer
// modport slave  : the JTAG host (nios2_debug_jtag_host)
// ---------------------------------------------------------------------------
interface nios2_debug_jtag_host_if
    import nios2_debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/nios2_debug_jtag_host_tckgen.sv
// ---------------------------------------------------------------------------
// nios2_debug_jtag_host_tckgen
// Test-clock divider. While run is high, tck is low for TCK_DIV clk cycles
// and then high for TCK_DIV. rise_en / fall_en are high during the clk
// cycle whose closing edge makes tck rise / fall, so logic clocked by clk
// can act on exactly that edge. With run low, tck is parked low and the
// divider is cleared, so each run starts with a full low phase.
// Ports: clk, reset_n (async low), run, tck, rise_en, fall_en.
// ---------------------------------------------------------------------------
module nios2_debug_jtag_host_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise_en,
    output logic fall_en
);
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap    = run && (cnt == CW'(TCK_DIV - 1));
    assign rise_en = wrap && !tck;
    assign fall_en = wrap &&  tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= !tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/nios2_debug_jtag_host.sv
// ---------------------------------------------------------------------------
// nios2_debug_jtag_host
// Initiator side of the Nios II virtual-JTAG debug-slave interface. Takes
// one command (IR code + DR payload), walks the slave through
// UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI, one tck period per state, and
// returns the tdo bits plus the ir_out value seen during CDR.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   bus (slave modport)     cmd_* request / rsp_* response handshake
//   tck, tdi, tdo           serial test clock and data
//   ir_in, ir_out           IR presented to / status from the debug slave
//   vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti   virtual-state strobes
//
// Optional build macro JTAG_HOST_IR_CACHE_EN: once a command has completed,
// a command whose IR matches the current ir_in skips UIR.
// ---------------------------------------------------------------------------
module nios2_debug_jtag_host
    import nios2_debug_jtag_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2_debug_jtag_host_if.slave bus,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    jtag_state_e         state_q, state_d;
    logic                run, rise_en, fall_en;
    logic                accept, last_bit, skip_uir, cmd_ready_c;
    logic [BW-1:0]       bit_cnt;
    logic [DR_WIDTH-1:0] dr_sh;     // outgoing payload, consumed LSB first
    logic [DR_WIDTH-1:0] cap;       // incoming tdo bits, filled from the MSB
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic                rsp_valid_q;
    logic                tdi_q;

    nios2_debug_jtag_host_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tck     (tck),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    assign accept   = bus.cmd_valid && cmd_ready_c;
    assign last_bit = (bit_cnt == BW'(DR_WIDTH - 1));

`ifdef JTAG_HOST_IR_CACHE_EN
    // ir_in still holds the last IR only once a full command has gone
    // through; after reset the slave's IR is unknown, so UIR is forced.
    logic done_once;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done_once <= 1'b0;
        else if (state_q == DONE && rsp_valid_q && bus.rsp_ready)
            done_once <= 1'b1;
    end

    assign skip_uir = done_once && (bus.cmd_ir == ir_in);
`else
    assign skip_uir = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ---- next state: every move except IDLE/DONE waits for tck falling ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) state_d = skip_uir ? CDR : UIR;
            UIR:  if (fall_en) state_d = CDR;
            CDR:  if (fall_en) state_d = SDR;
            SDR:  if (fall_en && last_bit) state_d = UDR;
            UDR:  if (fall_en) state_d = RTI;
            RTI:  if (fall_en) state_d = DONE;
            DONE: if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- outputs decoded from state ----
    always_comb begin
        cmd_ready_c    = 1'b0;
        run            = 1'b1;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        case (state_q)
            IDLE: begin cmd_ready_c = 1'b1; run = 1'b0; end
            UIR:  vs_uir         = 1'b1;
            CDR:  vs_cdr         = 1'b1;
            SDR:  vs_sdr         = 1'b1;
            UDR:  vs_udr         = 1'b1;
            RTI:  jtag_state_rti = 1'b1;
            default: run = 1'b0;
        endcase
    end

    // ---- datapath ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_in    <= '0;
            dr_sh    <= '0;
            cap      <= '0;
            bit_cnt  <= '0;
            tdi_q    <= 1'b0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
        end else begin
            if (accept) begin
                // tck is parked low in IDLE, so loading ir_in here is
                // equivalent to loading it at the start of the UIR period.
                ir_in <= bus.cmd_ir;
                dr_sh <= bus.cmd_dr;
            end else if (fall_en) begin
                // tdi follows the state that begins on this falling edge.
                if (state_d == SDR) begin
                    tdi_q <= dr_sh[0];
                    dr_sh <= dr_sh >> 1;
                end else begin
                    tdi_q <= 1'b0;
                end
            end

            if (fall_en && state_q == SDR)
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

            if (rise_en && state_q == CDR)
                rsp_ir_q <= ir_out;

            if (rise_en && state_q == SDR)
                cap <= {tdo, cap[DR_WIDTH-1:1]};

            // Publish the capture only when the sequence completes so an
            // aborted or in-flight command never disturbs rsp_dr.
            if (fall_en && state_q == RTI)
                rsp_dr_q <= cap;
        end
    end

    // rsp_valid is registered: it rises on the first clk edge spent in DONE
    // and drops on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rsp_valid_q <= 1'b0;
        else if (state_q == DONE)
            rsp_valid_q <= !(rsp_valid_q && bus.rsp_ready);
        else
            rsp_valid_q <= 1'b0;
    end

    assign tdi            = tdi_q;
    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign bus.rsp_ir_out = rsp_ir_q;
endmodule

// File: doc/nios2_debug_jtag_host.md
Name: nios2_debug_jtag_host

Overview:
Initiator side of the Nios II virtual-JTAG debug-slave interface. It accepts one debug command: a 2-bit IR code plus a 38-bit DR payload. It then drives the tck/tdi/ir_in and virtual-state strobes that the CPU debug slave consumes, and returns the 38 bits shifted out on tdo plus ir_out. Uses: in-fabric debug bridges, and closed-loop simulation of the debug slave without a physical JTAG hub.

Parameters:
TCK_DIV, 2, clk cycles per tck half-period (>=1)
DR_WIDTH, 38, data-register shift length
IR_WIDTH, 2, instruction-register width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_ir  in  IR_WIDTH  IR code (0 ocimem, 1 tracemem, 2 break, 3 tracectrl)
cmd_dr  in  DR_WIDTH  DR payload, shifted LSB first
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  response accept
rsp_dr  out  DR_WIDTH  captured tdo bits
rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR
tck  out  1  generated test clock
tdi  out  1  serial data to slave
tdo  in  1  serial data from slave
ir_in  out  IR_WIDTH  IR presented to slave
ir_out  in  IR_WIDTH  slave status bits
vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual state strobes

Behaviour:
- Reset (async assert, sync release): FSM IDLE; tck, tdi, all strobes, rsp_valid = 0; ir_in, rsp_dr, rsp_ir_out = 0; divider and bit counter = 0. Reset mid-shift aborts silently. No response is issued.
- tck timing: low for TCK_DIV clk cycles, then high for TCK_DIV. It runs only outside IDLE/DONE and idles low.
- State changes, strobe changes and tdi updates occur only with tck falling, i.e. at the start of a tck period. Samples (tdo, ir_out) are taken on the clk edge where tck rises.
- FSM, one tck period per state except SDR:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_ir/cmd_dr and go to UIR.
  - UIR: vs_uir=1; ir_in <= latched IR.
  - CDR: vs_cdr=1; sample ir_out into rsp_ir_out.
  - SDR: vs_sdr=1 for exactly DR_WIDTH tck periods. Bit k of cmd_dr drives tdi in period k. tdo shifts into the MSB of the capture register (right shift), so after DR_WIDTH bits rsp_dr[0] holds the first tdo bit.
  - UDR: vs_udr=1, tdi=0.
  - RTI: jtag_state_rti=1.
  - DONE: tck stopped low; rsp_valid=1 until rsp_ready, then IDLE.
- Exactly one strobe is high in each of UIR/CDR/SDR/UDR/RTI; none in IDLE/DONE.
- Latency: rsp_valid rises 2*TCK_DIV*(DR_WIDTH+4)+1 clk cycles after the accept edge (169 at defaults).
- rsp_valid && rsp_ready in DONE: returns to IDLE; cmd_ready asserts the next cycle (no same-cycle re-accept).
- cmd_valid outside IDLE is ignored; cmd_* is not sampled.
- ir_in holds its last value between commands.

Optional Feature:
JTAG_HOST_IR_CACHE_EN
- Defined: if latched IR equals current ir_in and at least one command has completed since reset, UIR is skipped (IDLE -> CDR). Latency drops by 2*TCK_DIV cycles.
- Undefined: UIR is always issued.

Decomposition:
- Package nios2_debug_jtag_pkg: FSM state enum (IDLE, UIR, CDR, SDR, UDR, RTI, DONE); IR code constants (OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3); default DR_WIDTH.
- Sub-module nios2_debug_jtag_host_tckgen: divider producing tck plus one-cycle rise/fall enables; gated by run.

Test Plan:
1. Reset with cmd_valid=1 -> all outputs 0, cmd_ready=1 after release, tck static low.
2. cmd_ir=2, cmd_dr=38'h2A_5555_AAAA; tdo looped from a 38-bit shift model preloaded 38'h15_1234_5678 -> rsp_dr=38'h15_1234_5678, model holds 38'h2A_5555_AAAA, rsp_valid at cycle 169.
3. ir_out=2'b10 held -> rsp_ir_out=2'b10; strobe counts UIR=1, CDR=1, SDR=38, UDR=1, RTI=1 tck periods, never two strobes high together.
4. rsp_ready held low 20 cycles -> rsp_valid and rsp_dr stable; cmd_valid meanwhile ignored; after accept, cmd_ready high next cycle.
5. Reset asserted at SDR bit 17 -> immediate return to reset values, no rsp_valid; next command completes normally.
6. With JTAG_HOST_IR_CACHE_EN, two consecutive cmd_ir=0 -> second has no vs_uir and latency 165; different IR -> vs_uir present.
